// File: rtl/baccarat_pkg.sv
// ----------------------------------------------------------------------------
// baccarat_pkg: FSM state type, card encoding and draw-rule thresholds.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package baccarat_pkg;

  typedef enum logic [3:0] {
    DEAL_P1 = 4'd0,
    DEAL_D1 = 4'd1,
    DEAL_P2 = 4'd2,
    DEAL_D2 = 4'd3,
    CHECK_P = 4'd4,
    DEAL_P3 = 4'd5,
    CHECK_D = 4'd6,
    DEAL_D3 = 4'd7,
    RESULT  = 4'd8,
    DONE    = 4'd9
  } state_t;

  localparam logic [3:0] CARD_NONE        = 4'd0;
  localparam logic [3:0] CARD_TEN         = 4'd10;
  localparam logic [3:0] NATURAL_MIN      = 4'd8;
  localparam logic [3:0] PLAYER_DRAW_MAX  = 4'd5;
  localparam logic [3:0] BANKER_STAND_MAX = 4'd5;

  // Out-of-range scores (>9) must never count as a natural.
  function automatic logic is_natural(input logic [3:0] score);
    return (score >= NATURAL_MIN) && (score <= 4'd9);
  endfunction

  // Tens and face cards are worth zero, as is an empty slot.
  function automatic logic [3:0] card_value(input logic [3:0] card);
    return (card < CARD_TEN) ? card : CARD_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/banker_draw_rule.sv
// ----------------------------------------------------------------------------
// banker_draw_rule: decides whether the banker takes a third card.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module banker_draw_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dealer_score,
  input  logic [3:0] v,
  input  logic       player_drew,
  output logic       draw
);

  always_comb begin
    draw = 1'b0;
    if (!player_drew) begin
      draw = (dealer_score <= BANKER_STAND_MAX);
    end else begin
      case (dealer_score)
        4'd0, 4'd1, 4'd2: draw = 1'b1;
        4'd3:             draw = (v != 4'd8);
        4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
        4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
        4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
        default:          draw = 1'b0;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/baccarat_controller.sv
// ----------------------------------------------------------------------------
// baccarat_controller: deal sequencing, third-card rules and win lights.
// Optional BACCARAT_AUTO_STEP_EN: internal step pulse every AUTO_PERIOD clks.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module baccarat_controller
  import baccarat_pkg::*;
#(
  parameter int unsigned AUTO_PERIOD = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  input  logic [3:0] player_score,
  input  logic [3:0] dealer_score,
  input  logic [3:0] player_third_card,
  output logic [2:0] deal_player_card,
  output logic [2:0] deal_dealer_card,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       game_over
);

  state_t state;
  logic   p3_dealt;
  logic   step;
  logic   step_live;
  logic   banker_draw;

`ifdef BACCARAT_AUTO_STEP_EN
  localparam int CNT_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  logic [CNT_W-1:0] auto_cnt;
  logic             auto_wrap;
  logic             unused_advance;

  assign unused_advance = advance;
  assign auto_wrap      = (auto_cnt == CNT_W'(AUTO_PERIOD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt <= '0;
    end else if (auto_wrap) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end

  assign step = auto_wrap;
`else
  assign step = advance;

  // Period only matters for the auto-step build; nothing is elaborated here.
  if (AUTO_PERIOD == 0) begin : g_no_auto_period
  end
`endif

  // Strobes are forced low while reset is held so no card loads mid-reset.
  assign step_live = step & rst_n;

  assign deal_player_card = {(state == DEAL_P3) & step_live,
                             (state == DEAL_P2) & step_live,
                             (state == DEAL_P1) & step_live};
  assign deal_dealer_card = {(state == DEAL_D3) & step_live,
                             (state == DEAL_D2) & step_live,
                             (state == DEAL_D1) & step_live};

  banker_draw_rule u_banker_draw_rule (
    .dealer_score (dealer_score),
    .v            (card_value(player_third_card)),
    .player_drew  (p3_dealt),
    .draw         (banker_draw)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= DEAL_P1;
      p3_dealt         <= 1'b0;
      player_win_light <= 1'b0;
      dealer_win_light <= 1'b0;
      game_over        <= 1'b0;
    end else begin
      case (state)
        DEAL_P1: if (step) state <= DEAL_D1;
        DEAL_D1: if (step) state <= DEAL_P2;
        DEAL_P2: if (step) state <= DEAL_D2;
        DEAL_D2: if (step) state <= CHECK_P;
        CHECK_P: begin
          if (is_natural(player_score) || is_natural(dealer_score)) begin
            state <= RESULT;
          end else if (player_score <= PLAYER_DRAW_MAX) begin
            state <= DEAL_P3;
          end else begin
            state <= CHECK_D;
          end
        end
        DEAL_P3: begin
          if (step) begin
            p3_dealt <= 1'b1;
            state    <= CHECK_D;
          end
        end
        CHECK_D: state <= banker_draw ? DEAL_D3 : RESULT;
        DEAL_D3: if (step) state <= RESULT;
        RESULT: begin
          player_win_light <= (player_score >= dealer_score);
          dealer_win_light <= (dealer_score >= player_score);
          game_over        <= 1'b1;
          state            <= DONE;
        end
        DONE:    state <= DONE;
        default: state <= DEAL_P1;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_baccarat_controller.sv
// ----------------------------------------------------------------------------
// tb_baccarat_controller: table-driven games with a strobe scoreboard.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_baccarat_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       advance = 1'b0;
  logic [3:0] player_score = 4'd0;
  logic [3:0] dealer_score = 4'd0;
  logic [3:0] player_third_card = 4'd0;
  logic [2:0] deal_player_card;
  logic [2:0] deal_dealer_card;
  logic       player_win_light;
  logic       dealer_win_light;
  logic       game_over;

  int tests  = 0;
  int failed = 0;

  // {player strobe, dealer strobe} expected for each step the bench issues
  logic [5:0] exp_q[$];

  typedef struct {
    logic [3:0] p2, d2, card, p3s, d3s;
    logic       p3, d3, pw, dw;
  } game_t;

  game_t games[16];

  baccarat_controller dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .advance           (advance),
    .player_score      (player_score),
    .dealer_score      (dealer_score),
    .player_third_card (player_third_card),
    .deal_player_card  (deal_player_card),
    .deal_dealer_card  (deal_dealer_card),
    .player_win_light  (player_win_light),
    .dealer_win_light  (dealer_win_light),
    .game_over         (game_over)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [5:0] obs;
    logic [5:0] e;
    obs = {deal_player_card, deal_dealer_card};
    if (obs != 6'd0) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL strobe_unexpected got=%b expected=none t=%0t", obs, $time);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          failed++;
          $display("FAIL strobe got=%b expected=%b t=%0t", obs, e, $time);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, got, want, $time);
    end
  endtask

  function automatic logic [31:0] outs();
    return {21'd0, deal_player_card, deal_dealer_card,
            player_win_light, dealer_win_light, game_over};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    advance = 1'b0;
    rst_n   = 1'b0;
    #1;
    check("reset_outputs", outs(), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  // Datapath-like: new scores become visible the cycle after the load edge.
  task automatic do_step(input logic [3:0] np, input logic [3:0] nd, input logic [5:0] e);
    exp_q.push_back(e);
    advance = 1'b1;
    @(posedge clk);
    #1;
    advance      = 1'b0;
    player_score = np;
    dealer_score = nd;
    idle(1);
  endtask

  task automatic run_game(input int idx, input game_t g);
    reset_dut();
    player_score      = g.p2;
    dealer_score      = g.d2;
    player_third_card = g.card;
    do_step(g.p2, g.d2, 6'b001_000);
    do_step(g.p2, g.d2, 6'b000_001);
    do_step(g.p2, g.d2, 6'b010_000);
    do_step(g.p2, g.d2, 6'b000_010);
    idle(1);
    if (g.p3) begin
      do_step(g.p3s, g.d2, 6'b100_000);
      idle(1);
    end
    if (g.d3) begin
      do_step(g.p3s, g.d3s, 6'b000_100);
    end
    idle(3);
    // Stepping in DONE must not produce strobes.
    advance = 1'b1;
    idle(2);
    advance = 1'b0;
    idle(1);
    check($sformatf("game%0d_lights", idx),
          {29'd0, player_win_light, dealer_win_light, game_over},
          {29'd0, g.pw, g.dw, 1'b1});
    check($sformatf("game%0d_queue", idx), exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    //            p2     d2     card    p3s    d3s    p3    d3    pw    dw
    games[0]  = '{4'd8, 4'd3, 4'd0,  4'd8, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0};
    games[1]  = '{4'd6, 4'd4, 4'd0,  4'd6, 4'd7, 1'b0, 1'b1, 1'b0, 1'b1};
    games[2]  = '{4'd3, 4'd3, 4'd8,  4'd1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b1};
    games[3]  = '{4'd3, 4'd3, 4'd13, 4'd3, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1};
    games[4]  = '{4'd2, 4'd6, 4'd7,  4'd9, 4'd9, 1'b1, 1'b1, 1'b1, 1'b1};
    games[5]  = '{4'd2, 4'd6, 4'd5,  4'd7, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0};
    games[6]  = '{4'd0, 4'd5, 4'd5,  4'd5, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1};
    games[7]  = '{4'd2, 4'd9, 4'd0,  4'd2, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1};
    games[8]  = '{4'd4, 4'd4, 4'd1,  4'd5, 4'd4, 1'b1, 1'b0, 1'b1, 1'b0};
    games[9]  = '{4'd5, 4'd7, 4'd6,  4'd1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1};
    games[10] = '{4'd7, 4'd6, 4'd0,  4'd7, 4'd6, 1'b0, 1'b0, 1'b1, 1'b0};
    games[11] = '{4'd1, 4'd2, 4'd8,  4'd9, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0};
    games[12] = '{4'd0, 4'd3, 4'd9,  4'd9, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0};
    games[13] = '{4'd4, 4'd6, 4'd6,  4'd0, 4'd6, 1'b1, 1'b1, 1'b0, 1'b1};
    games[14] = '{4'd9, 4'd9, 4'd0,  4'd9, 4'd9, 1'b0, 1'b0, 1'b1, 1'b1};
    games[15] = '{4'd4, 4'd5, 4'd11, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 16; i++) begin
      run_game(i, games[i]);
    end

    // Reset right after the D1 strobe, with advance held high during reset.
    reset_dut();
    player_score = 4'd0;
    dealer_score = 4'd0;
    do_step(4'd0, 4'd0, 6'b001_000);
    do_step(4'd0, 4'd0, 6'b000_001);
    advance = 1'b1;
    rst_n   = 1'b0;
    #1;
    check("midgame_reset_outputs", outs(), 32'd0);
    idle(2);
    check("midgame_reset_held", outs(), 32'd0);
    advance = 1'b0;
    rst_n   = 1'b1;
    idle(1);
    do_step(4'd0, 4'd0, 6'b001_000);
    idle(1);
    check("midgame_reset_queue", exp_q.size(), 32'd0);
    exp_q.delete();

    // advance held for 10 cycles: one strobe per cycle, no state skipped.
    reset_dut();
    player_score = 4'd7;
    dealer_score = 4'd7;
    exp_q.push_back(6'b001_000);
    exp_q.push_back(6'b000_001);
    exp_q.push_back(6'b010_000);
    exp_q.push_back(6'b000_010);
    advance = 1'b1;
    idle(10);
    advance = 1'b0;
    check("held_lights", {29'd0, player_win_light, dealer_win_light, game_over}, 32'd7);
    check("held_queue", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
